// File: rtl/seg_scan_if.sv
// seg_scan_if: image/mask inputs and scanned display outputs of seg_scan.
// master drives seg_in/sel_in(/dim); slave (seg_scan) drives seg/dig/frame.
interface seg_scan_if;
  logic [63:0] seg_in;
  logic [7:0]  sel_in;
`ifdef SEG_DIM_EN
  logic [3:0]  dim;
`endif
  logic [7:0]  seg;
  logic [7:0]  dig;
  logic        frame;

`ifdef SEG_DIM_EN
  modport master (
    output seg_in, sel_in, dim,
    input  seg, dig, frame
  );
  modport slave (
    input  seg_in, sel_in, dim,
    output seg, dig, frame
  );
`else
  modport master (
    output seg_in, sel_in,
    input  seg, dig, frame
  );
  modport slave (
    input  seg_in, sel_in,
    output seg, dig, frame
  );
`endif
endinterface

// File: rtl/seg_scan.sv
// seg_scan: 8-digit multiplexed segment driver, frame-buffered, slot blanking.
// Ports: clk, rst (sync, active-high), bus (seg_in, sel_in, [dim], seg, dig, frame).
// Optional SEG_DIM_EN macro adds the bus.dim brightness input.
module seg_scan #(
  parameter int DIV   = 1000,
  parameter int BLANK = 8
) (
  input  logic        clk,
  input  logic        rst,
  seg_scan_if.slave   bus
);

  localparam logic [15:0] LAST = 16'(DIV - 1);
  localparam logic [15:0] BL   = 16'(BLANK);

  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [63:0] sh_seg_q, sh_seg_d;
  logic [7:0]  sh_sel_q, sh_sel_d;
  logic [7:0]  seg_q, seg_d;
  logic [7:0]  dig_q, dig_d;
  logic        frame_q, frame_d;

  logic wrap;
  logic load;
  logic lit;

  always_comb begin
    wrap  = (cnt_q == LAST);
    load  = wrap && (idx_q == 3'd7);
    cnt_d = wrap ? 16'd0 : cnt_q + 16'd1;
    idx_d = wrap ? idx_q + 3'd1 : idx_q;

    // shadow only changes at the frame boundary, so a scan never tears
    sh_seg_d = load ? bus.seg_in : sh_seg_q;
    sh_sel_d = load ? bus.sel_in : sh_sel_q;
    frame_d  = load;

    lit = (cnt_q >= BL) && sh_sel_q[idx_q];
`ifdef SEG_DIM_EN
    // PWM within the lit window; dim is live, not shadowed
    lit = lit && (cnt_q[3:0] <= bus.dim);
`endif

    seg_d = 8'hFF;
    dig_d = 8'hFF;
    if (lit) begin
      seg_d = ~sh_seg_q[{idx_q, 3'b000} +: 8];
      dig_d = ~(8'b1 << idx_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      sh_seg_q <= '0;
      sh_sel_q <= '0;
      seg_q    <= 8'hFF;
      dig_q    <= 8'hFF;
      frame_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sh_seg_q <= sh_seg_d;
      sh_sel_q <= sh_sel_d;
      seg_q    <= seg_d;
      dig_q    <= dig_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.seg   = seg_q;
  assign bus.dig   = dig_q;
  assign bus.frame = frame_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: randomized self-checking bench for seg_scan.
// Reference model tracks frame position arithmetically and the loaded image.
module tb_seg_scan;

`ifdef SEG_DIM_EN
  localparam int DIV = 32;
`else
  localparam int DIV = 10;
`endif
  localparam int BLANK = 2;
  localparam int FR    = 8 * DIV;
  localparam logic [63:0] IMG = 64'h0123456789ABCDEF;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg_scan_if bus ();

  seg_scan #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model
  int          m_pos = 0;
  logic [63:0] m_sh  = '0;
  logic [7:0]  m_sel = '0;
  logic [7:0]  e_seg = 8'hFF;
  logic [7:0]  e_dig = 8'hFF;
  logic        e_frame = 1'b0;
  int          mc, mi;
  bit          mon;
  logic [7:0]  one_hot;

  always @(posedge clk) begin
    if (rst) begin
      m_pos = 0; m_sh = '0; m_sel = '0;
      e_seg = 8'hFF; e_dig = 8'hFF; e_frame = 1'b0;
    end else begin
      mc  = m_pos % DIV;
      mi  = m_pos / DIV;
      mon = (mc >= BLANK) && m_sel[mi];
`ifdef SEG_DIM_EN
      mon = mon && ((mc % 16) <= int'(bus.dim));
`endif
      one_hot = 8'h01 << mi;
      e_dig   = mon ? ~one_hot : 8'hFF;
      e_seg   = mon ? ~m_sh[8*mi +: 8] : 8'hFF;
      e_frame = (m_pos == FR - 1);
      if (e_frame) begin
        m_sh  = bus.seg_in;
        m_sel = bus.sel_in;
      end
      m_pos = (m_pos + 1) % FR;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.seg_in = IMG;
    bus.sel_in = 8'hFF;
`ifdef SEG_DIM_EN
    bus.dim = 4'd15;
`endif
    repeat (3) step();
    n_tests++;
    if (bus.seg !== 8'hFF || bus.dig !== 8'hFF || bus.frame !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_state: got seg=%h dig=%h frame=%b want FF FF 0",
               bus.seg, bus.dig, bus.frame);
    end
    rst = 1'b0;
    for (int k = 1; k <= FR; k++) begin
      step();
      n_tests++;
      if (bus.seg !== 8'hFF || bus.dig !== 8'hFF) begin
        n_fail++;
        $display("FAIL first_dark k=%0d: got seg=%h dig=%h want FF FF",
                 k, bus.seg, bus.dig);
      end
      n_tests++;
      if (bus.frame !== (k == FR)) begin
        n_fail++;
        $display("FAIL first_frame k=%0d: got %b want %b",
                 k, bus.frame, (k == FR));
      end
    end
  endtask

  task automatic test_scan();
    int c, d, blanks;
    logic [7:0] wd, ws;
    blanks = 0;
    for (int k = 1; k <= FR; k++) begin
      step();
      c = (k - 1) % DIV;
      d = (k - 1) / DIV;
      wd = 8'hFF;
      ws = 8'hFF;
      if (c >= BLANK) begin
        wd = ~(8'h01 << d);
        ws = ~IMG[8*d +: 8];
      end
      n_tests++;
      if (bus.dig !== wd || bus.seg !== ws) begin
        n_fail++;
        $display("FAIL scan k=%0d: got dig=%h seg=%h want %h %h",
                 k, bus.dig, bus.seg, wd, ws);
      end
      if (bus.dig === 8'hFF) blanks++;
      if (c == DIV - 1) begin
        n_tests++;
        if (blanks != BLANK) begin
          n_fail++;
          $display("FAIL slot_blank d=%0d: got %0d want %0d", d, blanks, BLANK);
        end
        blanks = 0;
      end
    end
    n_tests++;
    if (bus.frame !== 1'b1) begin
      n_fail++;
      $display("FAIL scan_frame: got %b want 1", bus.frame);
    end
  endtask

  task automatic test_tear();
    int c, d;
    for (int k = 1; k <= FR; k++) begin
      if (k - 1 == 3 * DIV + 4) bus.seg_in = '1;
      step();
      c = (k - 1) % DIV;
      d = (k - 1) / DIV;
      if (c >= BLANK) begin
        n_tests++;
        if (bus.seg !== ~IMG[8*d +: 8]) begin
          n_fail++;
          $display("FAIL tear_old k=%0d: got %h want %h",
                   k, bus.seg, ~IMG[8*d +: 8]);
        end
      end
    end
    for (int k = 1; k <= DIV; k++) begin
      step();
      if ((k - 1) >= BLANK) begin
        n_tests++;
        if (bus.seg !== 8'h00 || bus.dig !== 8'hFE) begin
          n_fail++;
          $display("FAIL tear_new k=%0d: got seg=%h dig=%h want 00 FE",
                   k, bus.seg, bus.dig);
        end
      end
    end
  endtask

  task automatic test_mask();
    bit seen;
    int c, d;
    bus.seg_in = {$urandom, $urandom};
    bus.sel_in = 8'b1010_0101;
    seen = 0;
    for (int k = 0; k <= FR && !seen; k++) begin
      step();
      if (bus.frame === 1'b1) seen = 1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL mask_wait: got no frame want frame within %0d", FR + 1);
    end
    for (int k = 1; k <= FR; k++) begin
      step();
      c = (k - 1) % DIV;
      d = (k - 1) / DIV;
      n_tests++;
      if (bus.dig !== e_dig || bus.seg !== e_seg) begin
        n_fail++;
        $display("FAIL mask_model k=%0d: got %h/%h want %h/%h",
                 k, bus.dig, bus.seg, e_dig, e_seg);
      end
      if (d == 1 || d == 3 || d == 4 || d == 6 || c < BLANK) begin
        n_tests++;
        if (bus.dig !== 8'hFF || bus.seg !== 8'hFF) begin
          n_fail++;
          $display("FAIL mask_dark k=%0d: got %h/%h want FF/FF",
                   k, bus.dig, bus.seg);
        end
      end
      n_tests++;
      if (bus.frame !== (k == FR)) begin
        n_fail++;
        $display("FAIL mask_period k=%0d: got %b want %b",
                 k, bus.frame, (k == FR));
      end
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    hit = 0;
    for (int k = 0; k < 2 * FR && !hit; k++) begin
      if (m_pos == 5 * DIV + 6) hit = 1;
      else step();
    end
    n_tests++;
    if (!hit) begin
      n_fail++;
      $display("FAIL rmid_wait: got no idx5/cnt6 want it within %0d", 2 * FR);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++;
    if (bus.seg !== 8'hFF || bus.dig !== 8'hFF || bus.frame !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_state: got %h/%h/%b want FF/FF/0",
               bus.seg, bus.dig, bus.frame);
    end
    for (int k = 1; k <= FR; k++) begin
      step();
      n_tests++;
      if (bus.seg !== 8'hFF || bus.dig !== 8'hFF ||
          bus.frame !== (k == FR)) begin
        n_fail++;
        $display("FAIL rmid_dark k=%0d: got %h/%h/%b want FF/FF/%b",
                 k, bus.seg, bus.dig, bus.frame, (k == FR));
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 4 * FR; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        bus.seg_in = {$urandom, $urandom};
        bus.sel_in = 8'($urandom);
      end
`ifdef SEG_DIM_EN
      if ($urandom_range(0, 7) == 0) bus.dim = 4'($urandom);
`endif
      step();
      n_tests++;
      if (bus.dig !== e_dig || bus.seg !== e_seg || bus.frame !== e_frame) begin
        n_fail++;
        $display("FAIL rand_model k=%0d: got %h/%h/%b want %h/%h/%b",
                 k, bus.dig, bus.seg, bus.frame, e_dig, e_seg, e_frame);
      end
      n_tests++;
      if ($countones(~bus.dig) > 1 ||
          (bus.dig === 8'hFF && bus.seg !== 8'hFF)) begin
        n_fail++;
        $display("FAIL rand_inv k=%0d: got dig=%h seg=%h want onehot/blank",
                 k, bus.dig, bus.seg);
      end
    end
  endtask

`ifdef SEG_DIM_EN
  task automatic run_dim(input logic [3:0] lvl, input int want);
    int lit;
    lit = 0;
    bus.dim = lvl;
    for (int k = 1; k <= FR; k++) begin
      step();
      if (bus.dig !== 8'hFF) lit++;
      if ((k - 1) % DIV == DIV - 1) begin
        n_tests++;
        if (lit != want) begin
          n_fail++;
          $display("FAIL dim%0d slot=%0d: got %0d lit want %0d",
                   lvl, (k - 1) / DIV, lit, want);
        end
        lit = 0;
      end
    end
  endtask

  task automatic test_dim();
    bit seen;
    bus.sel_in = 8'hFF;
    bus.seg_in = IMG;
    bus.dim    = 4'd15;
    seen = 0;
    for (int k = 0; k <= FR && !seen; k++) begin
      step();
      if (bus.frame === 1'b1) seen = 1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL dim_wait: got no frame want frame within %0d", FR + 1);
    end
    // cnt 2,3 and 16..19 in a 32-cycle slot
    run_dim(4'd3, 6);
    run_dim(4'd15, DIV - BLANK);
  endtask
`endif

  initial begin
    test_reset();
    test_scan();
    test_tear();
    test_mask();
    test_reset_mid();
    test_random();
`ifdef SEG_DIM_EN
    test_dim();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
